serial_addsub_ctrl: RTL and testbench
=====================================

# serial_addsub_ctrl

Bit-serial add/subtract sequencer that time-shares one 1-bit full adder/subtractor cell across a WIDTH-bit operation. It latches two operands and an opcode on a start handshake, steps the cell LSB-first over WIDTH cycles while holding the carry/borrow in a flip-flop, and reports the result with a one-cycle done pulse. It sits between a requesting controller and the team's 1-bit add/sub datapath, trading latency for area.

## Interface
- WIDTH, 8, operand/result width in bits; legal range 2..32.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  request; accepted only when ready=1.
- op  in  1  0 = add (a+b), 1 = subtract (a−b).
- a  in  WIDTH  first operand, sampled on the accepting edge.
- b  in  WIDTH  second operand, sampled on the accepting edge.
- ready  out  1  high in IDLE only.
- busy  out  1  high in RUN only.
- done  out  1  one-cycle pulse, high in DONE only.
- result  out  WIDTH  sum or difference, mod 2^WIDTH.
- cout  out  1  carry-out (add) or borrow-out (subtract) of the MSB.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE: ready=1. start=1 at an edge latches a, b and op into shift registers and the op register, clears the carry/borrow flop and the bit counter, and moves to RUN.
- RUN: each cycle the cell takes the LSB of a_sh and b_sh plus the carry/borrow flop.
  - add: s = a^b^c, c' = (a&b)|(b&c)|(c&a).
  - sub: d = a^b^c, c' = (~a&b)|(b&c)|(c&~a).
  - The s/d bit shifts into result_sh from the MSB side. a_sh and b_sh shift right. The flop takes c'. The counter increments.
  - After the counter reaches WIDTH−1, the FSM moves to DONE.
- DONE: done=1, result=result_sh, cout=flop. The FSM moves to IDLE on the next edge unconditionally.
- result and cout update only on entry to DONE. They hold until the next DONE entry or reset.
- start is ignored in RUN and DONE. It is not queued, and the inputs are not re-sampled.
- Operands and op are registered at acceptance. Changes to a, b or op afterwards do not affect the operation in flight.
- Reset values, applied asynchronously on rst_n low:
  - state=IDLE, ready=1, busy=0, done=0.
  - result=0, cout=0.
  - All shift registers, the counter and the flop cleared.
- Reset mid-RUN or mid-DONE aborts the operation. No done pulse is emitted, and the result is not updated.

## Timing
- start sampled high in IDLE at edge E0. busy is high from E0 through edge E0+WIDTH.
- done is high for exactly one cycle, between edges E0+WIDTH and E0+WIDTH+1. result and cout are valid from the same edge.
- ready returns high at E0+WIDTH+1. The earliest next acceptance is at that edge, giving a start-to-start period of WIDTH+1 cycles.
- ready, busy and done are mutually exclusive and one-hot at all times, reset included.
- Counter width is $clog2(WIDTH). The terminal count is WIDTH−1, so there is no wrap inside RUN.
- Arithmetic is unsigned modulo 2^WIDTH. cout=1 on add means unsigned overflow. cout=1 on subtract means a<b.

## Structure
- Shared package or include file holds:
  - the opcode constants OP_ADD=1'b0 and OP_SUB=1'b1;
  - the state encoding ST_IDLE, ST_RUN, ST_DONE, 2 bits.
- One sub-module: fa_fs_cell. It is a combinational 1-bit add/sub cell with ports (a, b, cin, op, s, cout), instantiated once.
- The top level holds the FSM, counter, operand/result shift registers and carry/borrow flop.

## Test plan
- Add, WIDTH=8: a=0x5A, b=0x3C, op=0 → result=0x96, cout=0; done exactly 8 cycles after the accepting edge.
- Add with overflow: a=0xFF, b=0x01, op=0 → result=0x00, cout=1.
- Subtract with borrow: a=0x10, b=0x20, op=1 → result=0xF0, cout=1. Then a=0x37, b=0x37, op=1 → result=0x00, cout=0.
- Start while busy:
  - Accept 0x12+0x34, then pulse start with a=0xFF, b=0xFF, op=1 at RUN cycle 3.
  - Required: result=0x46, cout=0, only one done pulse, second request dropped.
  - a and b also toggled mid-RUN; result unaffected.
- Reset mid-op:
  - Accept 0xAA+0x55, assert rst_n=0 during RUN cycle 4.
  - Required: immediately ready=1, busy=0, done=0, result=0, cout=0.
  - After release, a new 0x01+0x01 yields result=0x02.
- Back-to-back:
  - Hold start high continuously with alternating add/sub vectors.
  - Required: accepts every WIDTH+1 cycles; results match a reference model over 200 random vectors; ready/busy/done one-hot every cycle.

Source files
------------

// File: rtl/serial_addsub_ctrl_pkg.sv
// Shared opcode and FSM state encodings for the bit-serial add/sub sequencer.
package serial_addsub_ctrl_pkg;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/serial_addsub_ctrl_if.sv
// Request/response bundle between a controller (master) and the serial add/sub sequencer (slave).
interface serial_addsub_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic             op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             ready;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             cout;

    modport master (
        output start, op, a, b,
        input  ready, busy, done, result, cout
    );

    modport slave (
        input  start, op, a, b,
        output ready, busy, done, result, cout
    );
endinterface

// File: rtl/serial_addsub_ctrl_fa_fs_cell.sv
// Combinational 1-bit full adder / full subtractor; zero latency, no flow control.
// Subtract reuses the adder majority with the minuend inverted, yielding a borrow.
module fa_fs_cell
    import serial_addsub_ctrl_pkg::*;
(
    input  logic a,
    input  logic b,
    input  logic cin,
    input  logic op,
    output logic s,
    output logic cout
);
    logic a_eff;

    assign a_eff = a ^ (op == OP_SUB);
    assign s     = a ^ b ^ cin;
    assign cout  = (a_eff & b) | (b & cin) | (cin & a_eff);
endmodule

// File: rtl/serial_addsub_ctrl.sv
// Bit-serial WIDTH-bit add/sub: accepts a request when ready, done pulses WIDTH cycles later.
// Requests arriving while busy or done are dropped, not queued.
module serial_addsub_ctrl
    import serial_addsub_ctrl_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    serial_addsub_ctrl_if.slave   bus
);
    localparam int CNT_W = $clog2(WIDTH);

    state_e             state_q;
    logic               ready_q, busy_q, done_q;
    logic [WIDTH-1:0]   a_sh_q, b_sh_q, res_sh_q, result_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               op_q, carry_q, cout_q;
    logic               cell_s, cell_c;
    logic [WIDTH-1:0]   res_sh_d;

    fa_fs_cell u_cell (
        .a    (a_sh_q[0]),
        .b    (b_sh_q[0]),
        .cin  (carry_q),
        .op   (op_q),
        .s    (cell_s),
        .cout (cell_c)
    );

    // Result bits enter at the MSB so the LSB-first stream lands in place after WIDTH shifts.
    assign res_sh_d = {cell_s, res_sh_q[WIDTH-1:1]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            ready_q  <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            res_sh_q <= '0;
            result_q <= '0;
            cnt_q    <= '0;
            op_q     <= 1'b0;
            carry_q  <= 1'b0;
            cout_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.start) begin
                        a_sh_q  <= bus.a;
                        b_sh_q  <= bus.b;
                        op_q    <= bus.op;
                        carry_q <= 1'b0;
                        cnt_q   <= '0;
                        state_q <= ST_RUN;
                        ready_q <= 1'b0;
                        busy_q  <= 1'b1;
                    end
                end
                ST_RUN: begin
                    res_sh_q <= res_sh_d;
                    a_sh_q   <= a_sh_q >> 1;
                    b_sh_q   <= b_sh_q >> 1;
                    carry_q  <= cell_c;
                    cnt_q    <= cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(WIDTH - 1)) begin
                        result_q <= res_sh_d;
                        cout_q   <= cell_c;
                        state_q  <= ST_DONE;
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                    done_q  <= 1'b0;
                    ready_q <= 1'b1;
                end
                default: begin
                    state_q <= ST_IDLE;
                    ready_q <= 1'b1;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.ready  = ready_q;
    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.result = result_q;
    assign bus.cout   = cout_q;
endmodule

// File: tb/tb_serial_addsub_ctrl.sv
// Bench for serial_addsub_ctrl: transaction-level model checked every cycle plus directed literal cases.
module tb_serial_addsub_ctrl;
    import serial_addsub_ctrl_pkg::*;

    localparam int W = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    serial_addsub_ctrl_if #(.WIDTH(W)) bus ();

    serial_addsub_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: cycles left in the operation (0 idle, >1 running, 1 done cycle) and the visible outputs.
    int           m_left = 0;
    logic [W-1:0] m_pend_res = '0, m_res = '0;
    logic         m_pend_c = 1'b0, m_c = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        logic [W:0] wide;
        if (!rst_n) begin
            m_left = 0;
            m_res  = '0;
            m_c    = 1'b0;
        end else if (m_left == 0) begin
            if (bus.start) begin
                m_left = W + 1;
                if (bus.op == OP_ADD) begin
                    wide       = {1'b0, bus.a} + {1'b0, bus.b};
                    m_pend_res = wide[W-1:0];
                    m_pend_c   = wide[W];
                end else begin
                    m_pend_res = bus.a - bus.b;
                    m_pend_c   = (bus.a < bus.b);
                end
            end
        end else begin
            m_left--;
            if (m_left == 1) begin
                m_res = m_pend_res;
                m_c   = m_pend_c;
            end
        end
    end

    always @(negedge clk) begin
        chk("ready",  32'(bus.ready),  32'(m_left == 0));
        chk("busy",   32'(bus.busy),   32'(m_left > 1));
        chk("done",   32'(bus.done),   32'(m_left == 1));
        chk("result", 32'(bus.result), 32'(m_res));
        chk("cout",   32'(bus.cout),   32'(m_c));
        chk("onehot", 32'($onehot({bus.ready, bus.busy, bus.done})), 32'd1);
    end

    task automatic wait_idle();
        int k = 0;
        while (m_left != 0 && k < 100) begin
            @(negedge clk);
            k++;
        end
        chk("idle_timeout", 32'(m_left), 32'd0);
    endtask

    // Issue one request from a negedge; returns with the bench sitting in the done cycle.
    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic top,
                          output int lat);
        wait_idle();
        bus.a = ta; bus.b = tb_v; bus.op = top; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        lat = -1;
        for (int i = 0; i < 40; i++) begin
            if (bus.done) begin
                lat = i;
                break;
            end
            @(negedge clk);
        end
    endtask

    initial begin
        int lat;
        int dones;
        logic [W-1:0] seen_res;
        logic         seen_c;
        int accepted;
        int guard;

        bus.start = 1'b0; bus.op = OP_ADD; bus.a = '0; bus.b = '0;
        #12;
        chk("rst_ready", 32'(bus.ready), 32'd1);
        chk("rst_busy",  32'(bus.busy),  32'd0);
        chk("rst_res",   32'(bus.result), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        run_op(8'h5A, 8'h3C, OP_ADD, lat);
        chk("add_lat", 32'(lat), 32'd8);
        chk("add_res", 32'(bus.result), 32'h96);
        chk("add_c",   32'(bus.cout), 32'd0);

        run_op(8'hFF, 8'h01, OP_ADD, lat);
        chk("ovf_res", 32'(bus.result), 32'h00);
        chk("ovf_c",   32'(bus.cout), 32'd1);

        run_op(8'h10, 8'h20, OP_SUB, lat);
        chk("brw_res", 32'(bus.result), 32'hF0);
        chk("brw_c",   32'(bus.cout), 32'd1);

        run_op(8'h37, 8'h37, OP_SUB, lat);
        chk("eq_res", 32'(bus.result), 32'h00);
        chk("eq_c",   32'(bus.cout), 32'd0);

        // Start while busy, with operands toggled mid-run.
        wait_idle();
        bus.a = 8'h12; bus.b = 8'h34; bus.op = OP_ADD; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        bus.a = 8'hFF; bus.b = 8'hFF; bus.op = OP_SUB; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0; bus.a = 8'h0F; bus.b = 8'hF0;
        dones = 0; seen_res = '0; seen_c = 1'b1;
        for (int i = 0; i < 3 * W; i++) begin
            if (bus.done) begin
                dones++;
                seen_res = bus.result;
                seen_c   = bus.cout;
            end
            @(negedge clk);
        end
        chk("busy_dones", 32'(dones), 32'd1);
        chk("busy_res",   32'(seen_res), 32'h46);
        chk("busy_c",     32'(seen_c), 32'd0);

        // Reset during the fourth run cycle.
        wait_idle();
        bus.a = 8'hAA; bus.b = 8'h55; bus.op = OP_ADD; bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("mrst_ready", 32'(bus.ready),  32'd1);
        chk("mrst_busy",  32'(bus.busy),   32'd0);
        chk("mrst_done",  32'(bus.done),   32'd0);
        chk("mrst_res",   32'(bus.result), 32'd0);
        chk("mrst_c",     32'(bus.cout),   32'd0);
        @(negedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        run_op(8'h01, 8'h01, OP_ADD, lat);
        chk("post_rst_res", 32'(bus.result), 32'h02);

        // Back-to-back with start held high; a new vector is loaded after each acceptance.
        wait_idle();
        bus.a = W'($urandom); bus.b = W'($urandom); bus.op = OP_ADD; bus.start = 1'b1;
        accepted = 0;
        guard = 0;
        while (accepted < 200 && guard < 200 * (W + 4)) begin
            @(negedge clk);
            guard++;
            if (m_left == W + 1) begin
                accepted++;
                bus.a  = W'($urandom);
                bus.b  = W'($urandom);
                bus.op = ~bus.op;
            end
        end
        chk("b2b_count", 32'(accepted), 32'd200);
        bus.start = 1'b0;
        wait_idle();
        repeat (2) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
